// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Sized load/store to a word bus with byte enables, wait states,
//           read extension and misaligned/illegal/timeout error reporting.
// Rev     : 1.0  initial release
// ============================================================================
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_be,
   input  logic              bus_rvalid,
   input  logic [XLEN-1:0]   bus_rdata
);

   localparam int c_nb   = XLEN / 8;
   localparam int c_offw = $clog2(c_nb);
   localparam logic [7:0]      c_tmo_last = 8'(TIMEOUT - 1);
   localparam logic [c_nb-1:0] c_be_b     = c_nb'(1);
   localparam logic [c_nb-1:0] c_be_h     = c_nb'(3);
   localparam logic [c_nb-1:0] c_be_w     = c_nb'(15);

   localparam logic [1:0] c_err_ok  = 2'b00;
   localparam logic [1:0] c_err_mis = 2'b01;
   localparam logic [1:0] c_err_tmo = 2'b10;
   localparam logic [1:0] c_err_ill = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUS_ADDR = 2'd1,
      BUS_DATA = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt;
   logic [1:0]        r_err, w_err_nxt;
   logic [XLEN-1:0]   r_rdata, w_rdata_nxt;
   logic              w_capture;

   logic              r_we;
   logic [2:0]        r_funct3;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;

   logic              w_illegal;
   logic              w_misaligned;
   logic [c_offw-1:0] w_off;
   logic [c_offw+2:0] w_shamt;
   logic [XLEN-1:0]   w_shifted;
   logic [XLEN-1:0]   w_load;
   logic [c_nb-1:0]   w_be;
   logic [XLEN-1:0]   w_wdata;

   // Request classification on the incoming (not yet captured) request.
   assign w_illegal = (req_funct3 == 3'b111)
                   || (req_funct3[2] && req_we)
                   || ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));

   always_comb begin
      w_misaligned = 1'b0;
      case (req_funct3[1:0])
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = |req_addr[1:0];
         2'b11:   w_misaligned = |req_addr[2:0];
         default: w_misaligned = 1'b0;
      endcase
   end

   assign w_off     = r_addr[c_offw-1:0];
   assign w_shamt   = {w_off, 3'b000};
   assign w_shifted = bus_rdata >> w_shamt;

   always_comb begin
      w_load = w_shifted;
      case (r_funct3)
         3'b000:  w_load = XLEN'($signed(w_shifted[7:0]));
         3'b100:  w_load = XLEN'(w_shifted[7:0]);
         3'b001:  w_load = XLEN'($signed(w_shifted[15:0]));
         3'b101:  w_load = XLEN'(w_shifted[15:0]);
         3'b010:  w_load = XLEN'($signed(w_shifted[31:0]));
         3'b110:  w_load = XLEN'(w_shifted[31:0]);
         default: w_load = w_shifted;
      endcase
   end

   always_comb begin
      w_be    = '1;
      w_wdata = r_wdata;
      case (r_funct3[1:0])
         2'b00: begin
            w_be    = c_be_b << w_off;
            w_wdata = {c_nb{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = c_be_h << w_off;
            w_wdata = {(c_nb / 2){r_wdata[15:0]}};
         end
         2'b10: begin
            w_be    = c_be_w << w_off;
            w_wdata = {(XLEN / 32){r_wdata[31:0]}};
         end
         default: begin
            w_be    = '1;
            w_wdata = r_wdata;
         end
      endcase
   end

   // Next-state logic; a handshake is checked before the timeout limit so it wins a tie.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_rdata_nxt = r_rdata;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_capture   = 1'b1;
               w_rdata_nxt = '0;
               w_cnt_nxt   = '0;
               if (w_illegal) begin
                  w_err_nxt   = c_err_ill;
                  w_state_nxt = RESP;
               end else if (w_misaligned) begin
                  w_err_nxt   = c_err_mis;
                  w_state_nxt = RESP;
               end else begin
                  w_err_nxt   = c_err_ok;
                  w_state_nxt = BUS_ADDR;
               end
            end
         end
         BUS_ADDR: begin
            if (bus_ready) begin
               w_cnt_nxt   = '0;
               w_state_nxt = r_we ? RESP : BUS_DATA;
            end else if (r_cnt == c_tmo_last) begin
               w_err_nxt   = c_err_tmo;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         BUS_DATA: begin
            if (bus_rvalid) begin
               w_rdata_nxt = w_load;
               w_state_nxt = RESP;
            end else if (r_cnt == c_tmo_last) begin
               w_err_nxt   = c_err_tmo;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_err    <= '0;
         r_rdata  <= '0;
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;
         if (w_capture) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
         end
      end
   end

   assign req_ready = (r_state == IDLE);
   assign bus_valid = (r_state == BUS_ADDR);
   assign rsp_valid = (r_state == RESP);

   // Bus and response fields read as zero outside the phase that qualifies them.
   assign bus_we    = bus_valid & r_we;
   assign bus_addr  = bus_valid ? {r_addr[XLEN-1:c_offw], {c_offw{1'b0}}} : '0;
   assign bus_be    = bus_valid ? w_be : '0;
   assign bus_wdata = bus_valid ? w_wdata : '0;
   assign rsp_rdata = rsp_valid ? r_rdata : '0;
   assign rsp_err   = rsp_valid ? r_err : '0;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised load/store unit placed between the multicycle core datapath and the memory bus.
- Accepts one sized load/store request per transaction over a valid/ready handshake and drives a word-oriented bus with byte enables.
- Tolerates bus wait states, and aligns and sign/zero-extends read data.
- Reports misaligned access, illegal size and bus timeout as error codes instead of hanging the core.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT, 15, maximum cycles waited in BUS_ADDR or BUS_DATA before aborting; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets).
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- bus_valid  out  1  bus address phase valid.
- bus_ready  in  1  bus accepts address phase.
- bus_we  out  1  bus write.
- bus_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero).
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_be  out  XLEN/8  byte enables.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  XLEN  read data, full word.

Behaviour:
- Reset: state IDLE, all outputs 0 except req_ready=1, timeout counter 0, captured request cleared.
- FSM states: IDLE, BUS_ADDR, BUS_DATA, RESP.
- IDLE: req_ready=1. On req_valid, capture we/funct3/addr/wdata. If size is illegal or misaligned, go to RESP with the error code and never assert bus_valid. Otherwise go to BUS_ADDR.
- Illegal size: 011/110 when XLEN=32; 111 always; 1xx with req_we=1.
- Misaligned: H/HU with addr[0]!=0; W/WU with addr[1:0]!=0; D with addr[2:0]!=0.
- BUS_ADDR: bus_valid=1 and bus_addr/bus_we/bus_wdata/bus_be held stable until bus_ready.
  - On handshake, a store goes to RESP (err 00) and a load goes to BUS_DATA.
- BUS_DATA: wait for bus_rvalid. On rvalid, extract the field, extend it, register it, and go to RESP.
  - Extraction is bus_rdata >> (8*offset). B/H/W sign-extend; BU/HU/WU zero-extend; D passes through.
- Timeout counter: cleared on entry to BUS_ADDR and BUS_DATA, incremented each cycle without the awaited handshake.
  - When it reaches TIMEOUT, bus_valid drops the same cycle and the FSM goes to RESP with err 10.
  - bus_rvalid arriving after abort or outside BUS_DATA is ignored.
- RESP: rsp_valid=1 for exactly one cycle with registered rdata/err, then IDLE. req_ready=0 in every state except IDLE.
- Byte enables: B ones(1)<<off; H ones(2)<<off; W ones(4)<<off; D all ones; off=addr[log2(XLEN/8)-1:0].
- Store data: byte replicated to all lanes, half replicated, word replicated (XLEN=64), double passthrough.
- Latency, counted from the accept edge as cycle 0:
  - Error without bus access: rsp_valid in cycle 1.
  - Store with bus_ready immediate: bus_valid in cycle 1, rsp_valid in cycle 2.
  - Load with bus_ready immediate and rvalid one cycle later: rsp_valid in cycle 3.
- Reset mid-operation: a reset in any state returns to IDLE next edge, drops bus_valid and rsp_valid, and discards the captured request.
- Simultaneous bus_ready and the timeout limit in the same cycle: the handshake wins.

Test Plan:
- XLEN=32, SW addr 0x1000_0004 wdata 0xDEADBEEF, bus_ready=1 -> bus_addr 0x1000_0004, bus_be 4'b1111, bus_wdata 0xDEADBEEF; rsp_valid cycle 2, err 00.
- SH addr 0x1000_0002 wdata 0x0000ABCD -> bus_be 4'b1100, bus_wdata 0xABCDABCD, bus_addr 0x1000_0000.
- LB addr 0x2003, bus_rdata 0x8011_2233 -> rsp_rdata 0xFFFF_FF80, rsp_valid cycle 3; repeat as LBU -> 0x0000_0080; LHU addr 0x2002 -> 0x0000_8011.
- LH addr 0x2001 -> rsp_valid cycle 1, err 01, bus_valid never 1; SD under XLEN=32 -> err 11.
- TIMEOUT=15, LW with bus_ready held 0 -> bus_valid high 15 cycles then 0, rsp err 10; a later bus_rvalid is ignored and the next request is accepted normally.
- LW in BUS_DATA, rst=0 for one edge -> next cycle IDLE, req_ready=1, bus_valid 0, no rsp_valid; a late bus_rvalid produces no response.
